store_buffer: RTL and testbench
===============================

STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 Parameter DEPTH, default 4, sets the number of pending-store entries; it SHALL be a power of two, 2..16.
REQ-002 Port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst, input, 1, synchronous, active-high reset.
REQ-004 Port st_valid, input, 1, the pipeline presents a store this cycle.
REQ-005 Port st_addr, input, 16, word address of the store.
REQ-006 Port st_data, input, 16, store data.
REQ-007 Port st_ready, output, 1, the buffer can accept a store this cycle.
REQ-008 Port ld_valid, input, 1, the pipeline requests a load this cycle.
REQ-009 Port ld_addr, input, 16, word address of the load.
REQ-010 Port ld_data, output, 16, load result (combinational).
REQ-011 Port ld_stall, output, 1, load result is not valid this cycle; the pipeline SHALL retry.
REQ-012 Port mem_addr, output, 16, address to the data memory.
REQ-013 Port mem_wd, output, 16, write data to the data memory.
REQ-014 Port mem_we, output, 1, write enable to the data memory (the memory commits on the falling edge of clk).
REQ-015 Port mem_rd, input, 16, combinational read data from the data memory.
REQ-016 Port count, output, clog2(DEPTH)+1, number of valid entries.
REQ-017 Port empty, output, 1, high when count equals 0.

Function
REQ-018 Entries SHALL form a circular FIFO with head/tail pointers that wrap modulo DEPTH; each entry holds a 16-bit address and 16-bit data.
REQ-019 st_ready SHALL equal (count < DEPTH); a push occurs at the edge when st_valid && st_ready; st_valid while full SHALL be ignored with no state change.
REQ-020 Port arbitration per cycle: if ld_valid && !ld_stall, mem_addr=ld_addr and mem_we=0; otherwise, if not empty, mem_addr=head.addr, mem_wd=head.data and mem_we=1 (drain); otherwise mem_we=0.
REQ-021 A drain cycle SHALL pop the head at the following rising edge; there is exactly one memory write per entry, in FIFO order.
REQ-022 A simultaneous push and pop SHALL leave count unchanged and SHALL be legal at any count below DEPTH; at count==DEPTH a pop frees space only from the next cycle (no pass-through).
REQ-023 Load data SHALL be mem_rd unless forwarding applies (REQ-030); latency is zero cycles.
REQ-024 A store presented in the same cycle as a load to the same address SHALL NOT be visible to that load.
REQ-025 A push while empty SHALL cause no memory write in that cycle; the earliest write is the next cycle.

Reset
REQ-026 While rst is high, mem_we SHALL be 0, and at the edge count SHALL become 0, pointers 0, and all entries invalid.
REQ-027 After reset: st_ready=1, empty=1, count=0, ld_stall=0, mem_we=0.
REQ-028 Reset mid-operation SHALL discard all pending stores without writing them.

Configuration
REQ-029 Macro STORE_BUFFER_FWD_EN selects load forwarding.
REQ-030 With the macro defined, a load whose ld_addr matches any valid entry SHALL return the data of the youngest matching entry; ld_stall SHALL be tied to 0.
REQ-031 Without the macro, a load matching any valid entry SHALL assert ld_stall=1; the memory port then drains the head (REQ-020) until no entry matches, so that ld_stall deasserts and the load reads mem_rd.

Verification
REQ-032 Reset, then push (0x0010,0xAAAA) with idle loads -> next cycle mem_we=1, mem_addr=0x0010, mem_wd=0xAAAA; the cycle after that, empty=1.
REQ-033 Push 4 stores with ld_valid held high, DEPTH=4 -> count=4, st_ready=0, no mem_we; a 5th push is ignored; drop ld_valid -> 4 writes in order, count reaches 0.
REQ-034 FWD_EN: push (0x0020,0x1111), then (0x0020,0x2222); load 0x0020 -> ld_data=0x2222, ld_stall=0.
REQ-035 No FWD_EN: same stores, load 0x0020 -> ld_stall=1 for 2 cycles while both drain; then ld_stall=0 and ld_data=mem_rd=0x2222.
REQ-036 Three entries pending, assert rst for 1 cycle -> mem_we=0 during the reset cycle, count=0, memory contents unchanged.
REQ-037 At count=2, push and drain in the same cycle -> count stays 2; the tail pointer wraps from 3 to 0 correctly over 6 pushes.

Source files
------------

// File: rtl/store_buffer.sv
// Pending-store FIFO between the pipeline and a single-ported data memory.
// Define STORE_BUFFER_FWD_EN to forward load data from buffered stores instead of stalling.
module store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     st_valid,
    input  logic [15:0]              st_addr,
    input  logic [15:0]              st_data,
    output logic                     st_ready,
    input  logic                     ld_valid,
    input  logic [15:0]              ld_addr,
    output logic [15:0]              ld_data,
    output logic                     ld_stall,
    output logic [15:0]              mem_addr,
    output logic [15:0]              mem_wd,
    output logic                     mem_we,
    input  logic [15:0]              mem_rd,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [15:0]      addr_q [DEPTH];
    logic [15:0]      data_q [DEPTH];
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [AW-1:0]    head_q, head_d;
    logic [AW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;

    logic push, pop, load_go, any_match;

    assign count    = count_q;
    assign empty    = (count_q == '0);
    assign st_ready = (count_q < CW'(DEPTH));
    assign push     = st_valid && st_ready;

    // Only registered entries take part, so a same-cycle store stays invisible to the load.
    always_comb begin
        any_match = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (vld_q[k] && (addr_q[k] == ld_addr)) any_match = 1'b1;
        end
    end

`ifdef STORE_BUFFER_FWD_EN
    logic [15:0]   fwd_data;
    logic [AW-1:0] fwd_idx;

    // Walk oldest to youngest so the last hit is the youngest store.
    always_comb begin
        fwd_data = '0;
        fwd_idx  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            fwd_idx = head_q + AW'(k);
            if (vld_q[fwd_idx] && (addr_q[fwd_idx] == ld_addr)) fwd_data = data_q[fwd_idx];
        end
    end

    assign ld_stall = 1'b0;
    assign ld_data  = any_match ? fwd_data : mem_rd;
`else
    assign ld_stall = ld_valid && any_match;
    assign ld_data  = mem_rd;
`endif

    assign load_go = ld_valid && !ld_stall;

    always_comb begin
        mem_addr = addr_q[head_q];
        mem_wd   = data_q[head_q];
        mem_we   = 1'b0;
        if (load_go) begin
            mem_addr = ld_addr;
        end else if (!empty && !rst) begin
            mem_we = 1'b1;
        end
    end

    assign pop = mem_we;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        vld_d   = vld_q;
        if (pop) begin
            vld_d[head_q] = 1'b0;
            head_d        = head_q + AW'(1);
        end
        if (push) begin
            vld_d[tail_q] = 1'b1;
            tail_d        = tail_q + AW'(1);
        end
        count_d = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            vld_q   <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            vld_q   <= vld_d;
        end
    end

    // Payload storage needs no reset; validity lives in vld_q.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            addr_q[tail_q] <= st_addr;
            data_q[tail_q] <= st_data;
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Randomized and directed bench for store_buffer against a queue-based reference model.
// Follows STORE_BUFFER_FWD_EN the same way as the design.
module tb_store_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst, st_valid, st_ready, ld_valid, ld_stall, mem_we, empty;
    logic [15:0] st_addr, st_data, ld_addr, ld_data, mem_addr, mem_wd, mem_rd;
    logic [$clog2(DEPTH):0] count;

    logic [15:0] env_mem [0:65535];
    logic [15:0] ref_mem [0:65535];

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] d;
    } ent_t;
    ent_t q[$];

    int n_vec = 0;
    int n_err = 0;

    store_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_ready(st_ready),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_stall(ld_stall),
        .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd),
        .count(count), .empty(empty)
    );

    always #5 clk = ~clk;

    assign mem_rd = env_mem[mem_addr];

    always @(negedge clk) begin
        if (mem_we) env_mem[mem_addr] <= mem_wd;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle, check against the model, advance the model and the clock.
    task automatic step(input logic r, input logic sv, input logic [15:0] sa, input logic [15:0] sd,
                        input logic lv, input logic [15:0] la);
        bit          match, stall, go, we;
        logic [15:0] fwd;
        int          sz;
        rst = r; st_valid = sv; st_addr = sa; st_data = sd; ld_valid = lv; ld_addr = la;
        #3;
        match = 0;
        fwd   = '0;
        foreach (q[i]) begin
            if (q[i].a == la) begin
                match = 1;
                fwd   = q[i].d;
            end
        end
`ifdef STORE_BUFFER_FWD_EN
        stall = 0;
`else
        stall = lv && match;
`endif
        go = lv && !stall;
        we = !r && !go && (q.size() > 0);
        check("st_ready", 32'(st_ready), 32'(q.size() < DEPTH));
        check("count", 32'(count), 32'(q.size()));
        check("empty", 32'(empty), 32'(q.size() == 0));
        check("ld_stall", 32'(ld_stall), 32'(stall));
        check("mem_we", 32'(mem_we), 32'(we));
        if (go) begin
            check("mem_addr_ld", 32'(mem_addr), 32'(la));
        end else if (we) begin
            check("mem_addr_drain", 32'(mem_addr), 32'(q[0].a));
            check("mem_wd", 32'(mem_wd), 32'(q[0].d));
        end
        if (go && !r) begin
`ifdef STORE_BUFFER_FWD_EN
            check("ld_data", 32'(ld_data), 32'(match ? fwd : ref_mem[la]));
`else
            check("ld_data", 32'(ld_data), 32'(ref_mem[la]));
`endif
        end
        if (r) begin
            q.delete();
        end else begin
            sz = q.size();
            if (we) begin
                ref_mem[q[0].a] = q[0].d;
                void'(q.pop_front());
            end
            if (sv && sz < DEPTH) q.push_back(ent_t'{a: sa, d: sd});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin
            env_mem[i] = '0;
            ref_mem[i] = '0;
        end
        rst = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0; ld_valid = 1'b0; ld_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #2;
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_st_ready", 32'(st_ready), 32'd1);
        check("rst_ld_stall", 32'(ld_stall), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        @(posedge clk);
        #1;

        // Single store drains the next cycle.
        step(1'b0, 1'b1, 16'h0010, 16'hAAAA, 1'b0, 16'h0);
        check("d1_count", 32'(count), 32'd1);
        step(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
        check("d1_empty", 32'(empty), 32'd1);

        // Fill while loads block the port, 5th push ignored, then drain.
        for (int i = 0; i < 5; i++)
            step(1'b0, 1'b1, 16'h0030 + 16'(i), 16'hB000 + 16'(i), 1'b1, 16'h0100);
        check("d2_full_count", 32'(count), 32'd4);
        check("d2_full_ready", 32'(st_ready), 32'd0);
        idle(5);
        check("d2_drained", 32'(count), 32'd0);

        // Two stores to the same address, then load it.
        step(1'b0, 1'b1, 16'h0020, 16'h1111, 1'b1, 16'h0300);
        step(1'b0, 1'b1, 16'h0020, 16'h2222, 1'b1, 16'h0300);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 16'h0020);
        idle(3);

        // Reset discards three pending stores.
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b1, 16'h0050 + 16'(i), 16'hC000 + 16'(i), 1'b1, 16'h0300);
        step(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
        check("d4_count", 32'(count), 32'd0);
        idle(2);

        // Steady push + drain at count 2 wraps the pointers.
        for (int i = 0; i < 2; i++)
            step(1'b0, 1'b1, 16'h0060 + 16'(i), 16'hD000 + 16'(i), 1'b1, 16'h0300);
        for (int i = 0; i < 6; i++)
            step(1'b0, 1'b1, 16'h0062 + 16'(i), 16'hD002 + 16'(i), 1'b0, 16'h0);
        check("d5_count", 32'(count), 32'd2);
        idle(3);

        for (int i = 0; i < 800; i++) begin
            step(($urandom_range(0, 49) == 0),
                 ($urandom_range(0, 9) < 6),
                 16'h0040 + 16'($urandom_range(0, 7)),
                 16'($urandom),
                 ($urandom_range(0, 9) < 4),
                 16'h0040 + 16'($urandom_range(0, 7)));
        end
        idle(DEPTH + 2);

        for (int a = 0; a < 'h80; a++) check("mem_final", 32'(env_mem[a]), 32'(ref_mem[a]));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
